// File: rtl/grb_stream_receiver_if.sv
// Single-wire GRB line plus the decoded pixel/frame outputs of the receiver.
// master drives the LED line and observes the decode; slave is the receiver.
interface grb_stream_receiver_if;
   logic        Din;
   logic [23:0] PixelData;
   logic        PixelValid;
   logic [11:0] PixelCount;
   logic        FrameDone;
   logic        BitError;

   modport master (
      output Din,
      input  PixelData,
      input  PixelValid,
      input  PixelCount,
      input  FrameDone,
      input  BitError
   );

   modport slave (
      input  Din,
      output PixelData,
      output PixelValid,
      output PixelCount,
      output FrameDone,
      output BitError
   );
endinterface

// File: rtl/grb_stream_receiver.sv
// Receive side of the single-wire GRB LED protocol: pulse-width bit decode,
// 24-bit word assembly, per-frame pixel counting and latch-gap detection.
module grb_stream_receiver #(
   parameter int unsigned BIT_THRESH   = 30,
   parameter int unsigned MAX_HIGH     = 75,
   parameter int unsigned RESET_CYCLES = 2500
) (
   input  logic                  clk,
   input  logic                  reset,
   grb_stream_receiver_if.slave  bus
);

   localparam int unsigned HCW = $clog2(MAX_HIGH + 1);
   localparam int unsigned LCW = $clog2(RESET_CYCLES);
   localparam int unsigned PCW = 12;
   localparam int unsigned IDW = 5;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic [HCW-1:0]   high_cnt_q, high_cnt_d;
   logic [LCW-1:0]   low_cnt_q, low_cnt_d;
   logic [IDW-1:0]   bit_idx_q, bit_idx_d;
   logic [22:0]      sr_q, sr_d;
   logic [23:0]      pix_data_q, pix_data_d;
   logic             pix_valid_q, pix_valid_d;
   logic [PCW-1:0]   pix_count_q, pix_count_d;
   logic             frame_done_q, frame_done_d;
   logic             bit_error_q, bit_error_d;
   logic             frame_end_q, frame_end_d;

   logic             din_s;
   logic             bit_v;
   logic [23:0]      word_c;

   assign din_s  = sync2_q;
   assign bit_v  = (high_cnt_q >= HCW'(BIT_THRESH));
   assign word_c = {sr_q, bit_v};

   // Next-state and output decode; pulses default low every cycle.
   always_comb begin
      state_d      = state_q;
      high_cnt_d   = high_cnt_q;
      low_cnt_d    = low_cnt_q;
      bit_idx_d    = bit_idx_q;
      sr_d         = sr_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = 1'b0;
      pix_count_d  = pix_count_q;
      frame_done_d = 1'b0;
      bit_error_d  = 1'b0;
      frame_end_d  = frame_end_q;

      case (state_q)
         ST_SYNC: begin
            if (din_s) begin
               low_cnt_d = '0;
            end else if (low_cnt_q == LCW'(RESET_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               low_cnt_d = low_cnt_q + LCW'(1);
            end
         end

         ST_IDLE: begin
            if (din_s) begin
               state_d    = ST_HIGH;
               high_cnt_d = HCW'(1);
               if (bit_idx_q == '0 && frame_end_q) begin
                  pix_count_d = '0;
                  frame_end_d = 1'b0;
               end
            end
         end

         ST_HIGH: begin
            if (din_s) begin
               high_cnt_d = high_cnt_q + HCW'(1);
               // Over-long pulse: drop the partial word and resynchronise on a full gap.
               if (high_cnt_q == HCW'(MAX_HIGH - 1)) begin
                  bit_error_d = 1'b1;
                  bit_idx_d   = '0;
                  low_cnt_d   = '0;
                  state_d     = ST_SYNC;
               end
            end else begin
               sr_d      = word_c[22:0];
               state_d   = ST_LOW;
               low_cnt_d = LCW'(1);
               if (bit_idx_q == IDW'(23)) begin
                  pix_data_d  = word_c;
                  pix_valid_d = 1'b1;
                  bit_idx_d   = '0;
                  if (pix_count_q != '1) begin
                     pix_count_d = pix_count_q + PCW'(1);
                  end
               end else begin
                  bit_idx_d = bit_idx_q + IDW'(1);
               end
            end
         end

         ST_LOW: begin
            if (din_s) begin
               state_d    = ST_HIGH;
               high_cnt_d = HCW'(1);
            end else if (low_cnt_q == LCW'(RESET_CYCLES - 1)) begin
               frame_done_d = 1'b1;
               bit_error_d  = (bit_idx_q != '0);
               bit_idx_d    = '0;
               frame_end_d  = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               low_cnt_d = low_cnt_q + LCW'(1);
            end
         end

         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SYNC;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         high_cnt_q   <= '0;
         low_cnt_q    <= '0;
         bit_idx_q    <= '0;
         sr_q         <= '0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_count_q  <= '0;
         frame_done_q <= 1'b0;
         bit_error_q  <= 1'b0;
         frame_end_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         sync1_q      <= bus.Din;
         sync2_q      <= sync1_q;
         high_cnt_q   <= high_cnt_d;
         low_cnt_q    <= low_cnt_d;
         bit_idx_q    <= bit_idx_d;
         sr_q         <= sr_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         pix_count_q  <= pix_count_d;
         frame_done_q <= frame_done_d;
         bit_error_q  <= bit_error_d;
         frame_end_q  <= frame_end_d;
      end
   end

   assign bus.PixelData  = pix_data_q;
   assign bus.PixelValid = pix_valid_q;
   assign bus.PixelCount = pix_count_q;
   assign bus.FrameDone  = frame_done_q;
   assign bus.BitError   = bit_error_q;

endmodule

// File: tb/tb_grb_stream_receiver.sv
// Bench for grb_stream_receiver: directed and randomized GRB traffic compared
// against a pulse/gap-level model of the protocol.
module tb_grb_stream_receiver;

   localparam int unsigned BIT_THRESH = 30;
   localparam int unsigned MAX_HIGH   = 75;
   localparam int unsigned RC         = 2500;
   localparam int          CLK_P      = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   grb_stream_receiver_if bus ();

   grb_stream_receiver #(
      .BIT_THRESH   (BIT_THRESH),
      .MAX_HIGH     (MAX_HIGH),
      .RESET_CYCLES (RC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed pulses, collected away from the active edge
   logic [23:0] got_px[$];
   int   got_fd = 0, got_err = 0, got_fd_err = 0, pulse_viol = 0;
   logic pv_prev = 1'b0, fd_prev = 1'b0, be_prev = 1'b0;
   time  last_pv_t = 0, last_fd_t = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.PixelValid) begin
            got_px.push_back(bus.PixelData);
            last_pv_t = $time;
         end
         if (bus.FrameDone) begin
            got_fd++;
            last_fd_t = $time;
         end
         if (bus.BitError) got_err++;
         if (bus.FrameDone && bus.BitError) got_fd_err++;
         if ((bus.PixelValid && pv_prev) || (bus.FrameDone && fd_prev) ||
             (bus.BitError && be_prev) || (bus.PixelValid && bus.FrameDone))
            pulse_viol++;
         pv_prev = bus.PixelValid;
         fd_prev = bus.FrameDone;
         be_prev = bus.BitError;
      end else begin
         pv_prev = 1'b0;
         fd_prev = 1'b0;
         be_prev = 1'b0;
      end
   end

   // Protocol-level reference model
   bit          m_synced, m_in_frame, m_ended;
   int          m_idx, m_count;
   logic [23:0] m_sh, m_last;
   logic [23:0] exp_px[$];
   int          exp_fd = 0, exp_err = 0, exp_fd_err = 0;
   time         fall_t = 0;

   task automatic model_reset();
      m_synced   = 1'b0;
      m_in_frame = 1'b0;
      m_ended    = 1'b1;
      m_idx      = 0;
      m_count    = 0;
      m_sh       = '0;
      m_last     = '0;
   endtask

   task automatic low(input int l);
      if (l >= int'(RC)) begin
         if (!m_synced) begin
            m_synced = 1'b1;
         end else if (m_in_frame) begin
            exp_fd++;
            if (m_idx != 0) begin
               exp_err++;
               exp_fd_err++;
            end
            m_idx      = 0;
            m_ended    = 1'b1;
            m_in_frame = 1'b0;
         end
      end
      bus.Din = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic send_bit(input int h, input int l);
      if (m_synced) begin
         if (h >= int'(MAX_HIGH)) begin
            exp_err++;
            m_idx      = 0;
            m_synced   = 1'b0;
            m_in_frame = 1'b0;
         end else begin
            if (!m_in_frame && m_idx == 0 && m_ended) begin
               m_count = 0;
               m_ended = 1'b0;
            end
            m_sh       = {m_sh[22:0], (h >= int'(BIT_THRESH))};
            m_in_frame = 1'b1;
            m_idx++;
            if (m_idx == 24) begin
               exp_px.push_back(m_sh);
               m_last = m_sh;
               if (m_count < 4095) m_count++;
               m_idx = 0;
            end
         end
      end
      bus.Din = 1'b1;
      repeat (h) @(negedge clk);
      fall_t = $time;
      low(l);
   endtask

   // mode 0: nominal timing, 1: random timing, 2: 29/30 boundary, 3: 1/74 extremes
   task automatic send_pixel(input logic [23:0] val, input int mode, input int tail);
      for (int i = 23; i >= 0; i--) begin
         bit b;
         int h, l;
         b = val[i];
         case (mode)
            0:       begin h = b ? 40 : 20; l = b ? 22 : 42; end
            1:       begin h = b ? int'($urandom_range(74, 30)) : int'($urandom_range(29, 2));
                           l = int'($urandom_range(40, 1)); end
            2:       begin h = b ? 30 : 29; l = 5; end
            default: begin h = b ? 74 : 1;  l = 3; end
         endcase
         if (i == 0) l = tail;
         send_bit(h, l);
      end
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_npix"}, 32'(got_px.size()), 32'(exp_px.size()));
      while (got_px.size() > 0 && exp_px.size() > 0)
         chk({tag, "_pix"}, 32'(got_px.pop_front()), 32'(exp_px.pop_front()));
      got_px.delete();
      exp_px.delete();
      chk({tag, "_framedone"}, 32'(got_fd), 32'(exp_fd));
      chk({tag, "_biterror"}, 32'(got_err), 32'(exp_err));
      chk({tag, "_fd_with_err"}, 32'(got_fd_err), 32'(exp_fd_err));
      chk({tag, "_count"}, 32'(bus.PixelCount), 32'(m_count));
      chk({tag, "_data"}, 32'(bus.PixelData), 32'(m_last));
   endtask

   initial begin
      reset   = 1'b1;
      bus.Din = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      chk("rst_data",  32'(bus.PixelData), 32'h0);
      chk("rst_valid", 32'(bus.PixelValid), 32'h0);
      chk("rst_count", 32'(bus.PixelCount), 32'h0);
      chk("rst_fd",    32'(bus.FrameDone), 32'h0);
      chk("rst_err",   32'(bus.BitError), 32'h0);
      reset = 1'b0;

      // Single pixel after the initial gap, with exact latency checks
      low(RC);
      send_pixel(24'hFF0000, 0, 2600);
      chk("t1_pv_lat", 32'(last_pv_t - fall_t), 32'(3 * CLK_P));
      chk("t1_fd_lat", 32'(last_fd_t - fall_t), 32'((RC + 2) * CLK_P));
      check_frame("t1");

      // Three-pixel frame
      send_pixel(24'h123456, 0, 42);
      send_pixel(24'hABCDEF, 0, 22);
      send_pixel(24'h000001, 0, 2600);
      check_frame("t2");

      // Partial pixel at the gap
      for (int i = 0; i < 10; i++) send_bit((i % 2) ? 40 : 20, (i == 9) ? 2600 : 30);
      check_frame("t3");

      // Over-long high mid-pixel, resync, then a fresh pixel
      for (int i = 0; i < 5; i++) send_bit(40, 22);
      send_bit(100, 2600);
      check_frame("t4_err");
      send_pixel(24'hA5A5A5, 0, 2600);
      check_frame("t4_resume");

      // Boundary highs and a 2499-cycle low that must not latch
      send_pixel(24'h5A3C96, 2, RC - 1);
      send_pixel(24'hC3E10F, 3, 2600);
      check_frame("t5");

      // Reset in the middle of a pixel
      for (int i = 0; i < 12; i++) send_bit(40, 22);
      bus.Din = 1'b1;
      repeat (10) @(negedge clk);
      reset   = 1'b1;
      bus.Din = 1'b0;
      model_reset();
      got_px.delete();
      exp_px.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      low(2600);
      send_pixel(24'h0000FF, 0, 2600);
      check_frame("t6");

      // Randomized frames
      for (int f = 0; f < 3; f++) begin
         int np;
         np = int'($urandom_range(3, 1));
         for (int p = 0; p < np; p++)
            send_pixel(24'($urandom), 1,
                       (p == np - 1) ? int'($urandom_range(2600, 2510)) : int'($urandom_range(40, 1)));
         check_frame("rnd");
      end

      chk("pulse_rules", 32'(pulse_viol), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
